shiftreg_universal_burst: RTL and testbench

Parametrised successor to the team's fixed 8-bit serial-in/serial-out shift register. It supports four operations on every clock enable:
- hold
- shift left
- shift right
- parallel load
Shifts take their inserted bit either from serial input SI or by rotation. It adds a dynamic tap output and a burst engine that performs CNT back-to-back shifts and then signals DONE. It sits in serialiser/deserialiser and bit-banging datapaths.

---
 rtl/shiftreg_universal_burst.sv | 159 +++++++++++++++
 tb/tb_shiftreg_universal_burst.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_universal_burst.sv
// Parametrised universal shift register: hold / shift left / shift right / parallel load,
// with serial or rotate insertion, a dynamic tap and a CE-gated burst shift engine.
module shiftreg_universal_burst #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}},
    localparam int             CW    = $clog2(WIDTH + 1),
    localparam int             AW    = $clog2(WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic [1:0]       MODE,
    input  logic             ROT,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CW-1:0]    CNT,
    input  logic [AW-1:0]    A,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic             TAP,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] q_r, q_next_s;
    logic [CW-1:0]    rem_r, rem_next_s;
    logic             dir_left_r, dir_left_next_s;
    logic             rot_r, rot_next_s;
    logic             done_r, done_next_s;
    logic [CW-1:0]    cnt_eff_s;
    logic             tap_s;

    // One shift step; the inserted bit is either the bit leaving or SI.
    function automatic logic [WIDTH-1:0] shift_f(input logic [WIDTH-1:0] v,
                                                 input logic left,
                                                 input logic rot,
                                                 input logic si);
        logic ins;
        if (left) begin
            ins = rot ? v[WIDTH-1] : si;
            return {v[WIDTH-2:0], ins};
        end else begin
            ins = rot ? v[0] : si;
            return {ins, v[WIDTH-1:1]};
        end
    endfunction

    // Clamp the requested burst length to the register width.
    always_comb begin
        cnt_eff_s = CNT;
        if (CNT > CW'(WIDTH)) begin
            cnt_eff_s = CW'(WIDTH);
        end else begin
            cnt_eff_s = CNT;
        end
    end

    // Next-state, next-data and DONE decode for the IDLE/BUSY engine.
    always_comb begin
        state_next_s    = state_r;
        q_next_s        = q_r;
        rem_next_s      = rem_r;
        dir_left_next_s = dir_left_r;
        rot_next_s      = rot_r;
        done_next_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CE && START && (MODE == 2'b01 || MODE == 2'b10)) begin
                    dir_left_next_s = (MODE == 2'b01);
                    rot_next_s      = ROT;
                    if (cnt_eff_s == {CW{1'b0}}) begin
                        done_next_s = 1'b1;
                    end else begin
                        q_next_s   = shift_f(q_r, MODE == 2'b01, ROT, SI);
                        rem_next_s = cnt_eff_s - CW'(1);
                        // A single-shift burst finishes without visiting BUSY.
                        if (cnt_eff_s == CW'(1)) begin
                            done_next_s = 1'b1;
                        end else begin
                            state_next_s = ST_BUSY;
                        end
                    end
                end else if (CE) begin
                    case (MODE)
                        2'b00:   q_next_s = q_r;
                        2'b01:   q_next_s = shift_f(q_r, 1'b1, ROT, SI);
                        2'b10:   q_next_s = shift_f(q_r, 1'b0, ROT, SI);
                        2'b11:   q_next_s = D;
                        default: q_next_s = q_r;
                    endcase
                end else begin
                    q_next_s = q_r;
                end
            end
            ST_BUSY: begin
                if (CE) begin
                    q_next_s   = shift_f(q_r, dir_left_r, rot_r, SI);
                    rem_next_s = rem_r - CW'(1);
                    if (rem_r == CW'(1)) begin
                        state_next_s = ST_IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, data and burst bookkeeping registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            state_r    <= ST_IDLE;
            q_r        <= INIT;
            rem_r      <= {CW{1'b0}};
            dir_left_r <= 1'b0;
            rot_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            q_r        <= q_next_s;
            rem_r      <= rem_next_s;
            dir_left_r <= dir_left_next_s;
            rot_r      <= rot_next_s;
            done_r     <= done_next_s;
        end
    end

    // Dynamic tap; out-of-range selects read as zero.
    always_comb begin
        tap_s = 1'b0;
        if (int'(A) < WIDTH) begin
            tap_s = q_r[A];
        end else begin
            tap_s = 1'b0;
        end
    end

    assign Q    = q_r;
    assign SOL  = q_r[WIDTH-1];
    assign SOR  = q_r[0];
    assign TAP  = tap_s;
    assign BUSY = (state_r == ST_BUSY);
    assign DONE = done_r;

endmodule

// File: tb/tb_shiftreg_universal_burst.sv
// Directed self-checking bench for shiftreg_universal_burst (WIDTH=8, INIT=0).
module tb_shiftreg_universal_burst;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int AW    = 3;

    logic             C = 1'b0;
    logic             R, CE, ROT, SI, START;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] D;
    logic [CW-1:0]    CNT;
    logic [AW-1:0]    A;
    logic [WIDTH-1:0] Q;
    logic             SOL, SOR, TAP, BUSY, DONE;

    int n_pass  = 0;
    int n_total = 0;

    shiftreg_universal_burst dut (
        .C(C), .R(R), .CE(CE), .MODE(MODE), .ROT(ROT), .SI(SI), .D(D),
        .START(START), .CNT(CNT), .A(A),
        .Q(Q), .SOL(SOL), .SOR(SOR), .TAP(TAP), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 C = ~C;

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        CE = 1'b1; START = 1'b0; MODE = 2'b11; D = v;
        step();
        MODE = 2'b00;
    endtask

    logic [WIDTH-1:0] sl_exp [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB1};
    logic             si_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] rr_exp [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};

    initial begin
        R = 1'b1; CE = 1'b0; MODE = 2'b00; ROT = 1'b0; SI = 1'b0;
        D = 8'h00; START = 1'b0; CNT = 4'd0; A = 3'd0;

        // 1. Reset and parallel load
        step(); step();
        check("reset_q", 32'(Q), 32'h00);
        check("reset_busy", 32'(BUSY), 32'h0);
        check("reset_done", 32'(DONE), 32'h0);
        R = 1'b0;
        load(8'hA5);
        check("load_q", 32'(Q), 32'hA5);
        check("load_sol", 32'(SOL), 32'h1);
        check("load_sor", 32'(SOR), 32'h1);
        A = 3'd1;
        #1 check("tap_a1", 32'(TAP), 32'h0);
        A = 3'd2;
        #1 check("tap_a2", 32'(TAP), 32'h1);

        // 2. Serial shift left with a CE stall mid-stream
        load(8'h00);
        MODE = 2'b01; ROT = 1'b0;
        for (int i = 0; i < 8; i++) begin
            CE = 1'b1; SI = si_seq[i];
            step();
            check($sformatf("shl_%0d", i), 32'(Q), 32'(sl_exp[i]));
            if (i == 3) begin
                CE = 1'b0; SI = 1'b1;
                step(); step();
                check("shl_stall", 32'(Q), 32'h0B);
            end
        end
        A = 3'd3;
        #1 check("tap_a3", 32'(TAP), 32'h0);
        A = 3'd7;
        #1 check("tap_a7", 32'(TAP), 32'h1);

        // 3. Rotate right
        load(8'h81);
        MODE = 2'b10; ROT = 1'b1; SI = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rotr_%0d", i), 32'(Q), 32'(rr_exp[i]));
        end

        // 4a. Burst of 3 left rotations
        load(8'h01);
        START = 1'b1; MODE = 2'b01; ROT = 1'b1; CNT = 4'd3;
        step();
        START = 1'b0; MODE = 2'b00; ROT = 1'b0; CNT = 4'd0;
        check("b3_q1", 32'(Q), 32'h02);
        check("b3_busy1", 32'(BUSY), 32'h1);
        check("b3_done1", 32'(DONE), 32'h0);
        step();
        check("b3_q2", 32'(Q), 32'h04);
        check("b3_busy2", 32'(BUSY), 32'h1);
        step();
        check("b3_q3", 32'(Q), 32'h08);
        check("b3_busy3", 32'(BUSY), 32'h0);
        check("b3_done3", 32'(DONE), 32'h1);
        step();
        check("b3_done_clr", 32'(DONE), 32'h0);
        check("b3_q_after", 32'(Q), 32'h08);

        // 4b. Same burst with one stalled cycle; DONE clears even with CE low
        load(8'h01);
        START = 1'b1; MODE = 2'b01; ROT = 1'b1; CNT = 4'd3;
        step();
        START = 1'b0; MODE = 2'b00; ROT = 1'b0;
        CE = 1'b0;
        step();
        check("bs_q_stall", 32'(Q), 32'h02);
        check("bs_busy_stall", 32'(BUSY), 32'h1);
        check("bs_done_stall", 32'(DONE), 32'h0);
        CE = 1'b1;
        step();
        check("bs_q2", 32'(Q), 32'h04);
        check("bs_done2", 32'(DONE), 32'h0);
        step();
        check("bs_q3", 32'(Q), 32'h08);
        check("bs_done3", 32'(DONE), 32'h1);
        CE = 1'b0;
        step();
        check("bs_done_ce0", 32'(DONE), 32'h0);
        CE = 1'b1;

        // 5a. CNT=0 burst
        load(8'h5A);
        START = 1'b1; MODE = 2'b01; CNT = 4'd0;
        step();
        START = 1'b0; MODE = 2'b00;
        check("c0_q", 32'(Q), 32'h5A);
        check("c0_done", 32'(DONE), 32'h1);
        check("c0_busy", 32'(BUSY), 32'h0);
        step();
        check("c0_done_clr", 32'(DONE), 32'h0);

        // 5b. START with load mode is a plain load
        START = 1'b1; MODE = 2'b11; D = 8'h3C; CNT = 4'd3;
        step();
        START = 1'b0; MODE = 2'b00;
        check("sl_q", 32'(Q), 32'h3C);
        check("sl_busy", 32'(BUSY), 32'h0);
        check("sl_done", 32'(DONE), 32'h0);
        step();
        check("sl_done2", 32'(DONE), 32'h0);

        // 5c. START ignored while CE is low in IDLE
        CE = 1'b0; START = 1'b1; MODE = 2'b01; CNT = 4'd2; SI = 1'b1;
        step();
        CE = 1'b1; START = 1'b0; MODE = 2'b00; SI = 1'b0;
        check("ce0_q", 32'(Q), 32'h3C);
        check("ce0_busy", 32'(BUSY), 32'h0);
        step();
        check("ce0_busy2", 32'(BUSY), 32'h0);
        check("ce0_done", 32'(DONE), 32'h0);

        // 5d. CNT=9 clamps to 8 rotations
        load(8'h01);
        START = 1'b1; MODE = 2'b01; ROT = 1'b1; CNT = 4'd9;
        step();
        START = 1'b0; MODE = 2'b00; ROT = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("c9_q7", 32'(Q), 32'h80);
        check("c9_busy7", 32'(BUSY), 32'h1);
        step();
        check("c9_q8", 32'(Q), 32'h01);
        check("c9_busy8", 32'(BUSY), 32'h0);
        check("c9_done8", 32'(DONE), 32'h1);

        // 5e. Back-to-back burst accepted while DONE is high; SI sampled live
        START = 1'b1; MODE = 2'b10; ROT = 1'b0; SI = 1'b1; CNT = 4'd2;
        step();
        START = 1'b0; MODE = 2'b00; SI = 1'b0;
        check("bb_q1", 32'(Q), 32'h80);
        check("bb_busy1", 32'(BUSY), 32'h1);
        check("bb_done1", 32'(DONE), 32'h0);
        step();
        check("bb_q2", 32'(Q), 32'h40);
        check("bb_done2", 32'(DONE), 32'h1);

        // 6. Reset aborts a burst; a new burst follows immediately
        load(8'h01);
        START = 1'b1; MODE = 2'b01; ROT = 1'b1; CNT = 4'd8;
        step();
        START = 1'b0; MODE = 2'b00; ROT = 1'b0;
        step();
        check("rb_q2", 32'(Q), 32'h04);
        R = 1'b1;
        step();
        R = 1'b0;
        check("rb_q_rst", 32'(Q), 32'h00);
        check("rb_busy_rst", 32'(BUSY), 32'h0);
        check("rb_done_rst", 32'(DONE), 32'h0);
        START = 1'b1; MODE = 2'b01; ROT = 1'b0; SI = 1'b1; CNT = 4'd2;
        step();
        START = 1'b0; MODE = 2'b00;
        check("rb_new_q1", 32'(Q), 32'h01);
        check("rb_new_busy", 32'(BUSY), 32'h1);
        check("rb_new_done1", 32'(DONE), 32'h0);
        step();
        check("rb_new_q2", 32'(Q), 32'h03);
        check("rb_new_done2", 32'(DONE), 32'h1);
        step();
        check("rb_new_done3", 32'(DONE), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
